// File: rtl/game_pkg.sv
// Shared definitions for the game blocks: character codes, name length
// and the name-entry FSM state encoding.
package game_pkg;

    localparam int CODE_W     = 6;
    localparam int NAME_LEN   = 5;
    localparam int CODE_A     = 0;
    localparam int CODE_BLANK = 26;

    typedef enum logic [1:0] {
        NE_IDLE,
        NE_EDIT,
        NE_DONE,
        NE_WAIT_RELEASE
    } ne_state_e;

    // Step a character code up or down, wrapping within 0..max_code.
    function automatic logic [CODE_W-1:0] code_step(
        input logic [CODE_W-1:0] code,
        input logic              up,
        input logic [CODE_W-1:0] max_code
    );
        if (up) begin
            return (code >= max_code) ? '0 : code + 1'b1;
        end
        return (code == '0) ? max_code : code - 1'b1;
    endfunction

endpackage

// File: rtl/edge_pulse.sv
// Registered rising-edge detector for one conditioned button.
// The pulse is high for one cycle after the input first samples high.
module edge_pulse (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic pulse
);

    logic prev;

    // Track the previous level and flag a low-to-high transition.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            prev  <= d;
            pulse <= d & ~prev;
        end
    end

endmodule

// File: rtl/name_entry.sv
// High-score name entry: five character codes edited with up/down/next.
// Define NAME_ENTRY_TIMEOUT_EN to auto-commit after TIMEOUT_CYCLES idle.
module name_entry
    import game_pkg::*;
#(
    parameter int NUM_CODES      = 27,
    parameter int INIT_CODE      = CODE_A,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_next,
    output logic [CODE_W-1:0] letter1,
    output logic [CODE_W-1:0] letter2,
    output logic [CODE_W-1:0] letter3,
    output logic [CODE_W-1:0] letter4,
    output logic [CODE_W-1:0] letter5,
    output logic              doneSave,
    output logic [2:0]        cursor,
    output logic              busy
);

    if (NUM_CODES < 2 || NUM_CODES > 64) begin : g_bad_codes
        $error("name_entry: NUM_CODES must be 2..64");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("name_entry: TIMEOUT_CYCLES must be >= 1");
    end

    localparam logic [CODE_W-1:0] MAX_CODE = CODE_W'(NUM_CODES - 1);
    localparam logic [CODE_W-1:0] INIT_VAL = CODE_W'(INIT_CODE);
    localparam logic [2:0]        LAST_POS = 3'(NAME_LEN - 1);

    ne_state_e                           state;
    logic [NAME_LEN-1:0][CODE_W-1:0]     letters;
    logic                                up_ev;
    logic                                down_ev;
    logic                                next_ev;

`ifdef NAME_ENTRY_TIMEOUT_EN
    localparam int           TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYCLES);
    logic [TW-1:0]           to_cnt;
`endif

    edge_pulse u_up (
        .clk    (clk),
        .resetn (resetn),
        .d      (btn_up),
        .pulse  (up_ev)
    );

    edge_pulse u_down (
        .clk    (clk),
        .resetn (resetn),
        .d      (btn_down),
        .pulse  (down_ev)
    );

    edge_pulse u_next (
        .clk    (clk),
        .resetn (resetn),
        .d      (btn_next),
        .pulse  (next_ev)
    );

    assign letter1 = letters[0];
    assign letter2 = letters[1];
    assign letter3 = letters[2];
    assign letter4 = letters[3];
    assign letter5 = letters[4];

    // Session FSM; letters, cursor, doneSave and busy are all registered here.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= NE_IDLE;
            letters  <= {NAME_LEN{INIT_VAL}};
            cursor   <= '0;
            doneSave <= 1'b0;
            busy     <= 1'b0;
`ifdef NAME_ENTRY_TIMEOUT_EN
            to_cnt   <= '0;
`endif
        end else begin
            unique case (state)
                NE_IDLE: begin
                    doneSave <= 1'b0;
                    busy     <= 1'b0;
                    if (start) begin
                        state   <= NE_EDIT;
                        letters <= {NAME_LEN{INIT_VAL}};
                        cursor  <= '0;
                        busy    <= 1'b1;
`ifdef NAME_ENTRY_TIMEOUT_EN
                        to_cnt  <= TO_LOAD;
`endif
                    end
                end
                NE_EDIT: begin
                    if (!start) begin
                        state  <= NE_IDLE;
                        cursor <= '0;
                        busy   <= 1'b0;
                    end else begin
                        // Opposing edges in one cycle cancel out.
                        if (up_ev ^ down_ev) begin
                            letters[cursor] <=
                                code_step(letters[cursor], up_ev, MAX_CODE);
                        end
                        if (next_ev) begin
                            if (cursor == LAST_POS) begin
                                state <= NE_DONE;
                            end else begin
                                cursor <= cursor + 3'd1;
                            end
                        end
`ifdef NAME_ENTRY_TIMEOUT_EN
                        // Any activity restarts the idle window.
                        if (up_ev || down_ev || next_ev) begin
                            to_cnt <= TO_LOAD;
                        end else if (to_cnt == '0 || to_cnt == TW'(1)) begin
                            to_cnt <= '0;
                            state  <= NE_DONE;
                        end else begin
                            to_cnt <= to_cnt - 1'b1;
                        end
`endif
                    end
                end
                NE_DONE: begin
                    doneSave <= 1'b1;
                    state    <= NE_WAIT_RELEASE;
                end
                NE_WAIT_RELEASE: begin
                    doneSave <= 1'b0;
                    busy     <= 1'b0;
                    if (!start) begin
                        state <= NE_IDLE;
                    end
                end
                default: state <= NE_IDLE;
            endcase
        end
    end

endmodule
